// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the in-order pipeline writeback
// and the MDU. The pipeline wins by default. MDU results queue in a 2-entry
// FIFO and drain on idle write slots. If the FIFO head waits STARVE_LIMIT
// cycles, a one-cycle FORCE state stalls the pipeline so the head can drain.
// A pipeline write to address A removes every queued MDU result for A, because
// the pipeline write is the younger one.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pipe_we,
  input  logic [ADDR_W-1:0] i_pipe_addr,
  input  logic [DATA_W-1:0] i_pipe_data,
  input  logic              i_mdu_valid,
  input  logic [ADDR_W-1:0] i_mdu_addr,
  input  logic [DATA_W-1:0] i_mdu_data,
  output logic              o_mdu_ready,
  output logic              o_stall_pipe,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_data,
  output logic              o_busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        count_reg, count_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic              wr_ptr_reg, wr_ptr_next;
  logic [SW-1:0]     starve_reg, starve_next;
  logic              rf_we_reg, rf_we_next;
  logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
  logic [DATA_W-1:0] rf_data_reg, rf_data_next;

  // FIFO storage; the head is read combinationally so it can drain in the
  // same cycle it is granted.
  logic [ADDR_W-1:0] mem_addr [2];
  logic [DATA_W-1:0] mem_data [2];

  logic       head_valid;
  logic       second_valid;
  logic       pipe_grant;
  logic       pop;
  logic       push;
  logic [1:0] slot_valid;
  logic [1:0] squash;
  logic       keep_head;
  logic       keep_second;
  logic [1:0] count_after;
  logic       rd_after;
  logic       wr_after;

  assign head_valid   = (count_reg != 2'd0);
  assign second_valid = (count_reg == 2'd2);

  // A write to r0 is never a pipeline grant, and FORCE ignores the pipeline.
  assign pipe_grant = (state_reg != ST_FORCE) && i_pipe_we && (i_pipe_addr != '0);
  assign pop        = (state_reg == ST_FORCE) || (!pipe_grant && head_valid);
  assign push       = i_mdu_valid && o_mdu_ready;

  // Per-slot validity and same-address squash against a granted pipeline write.
  // Entries pushed this cycle are written after removal, so they are never
  // squashed.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_valid[gi] = second_valid ||
                              (head_valid && (rd_ptr_reg == 1'(gi)));
      assign squash[gi]     = pipe_grant && slot_valid[gi] &&
                              (mem_addr[gi] == i_pipe_addr);
    end
  endgenerate

  // Port grant, FIFO removal/insert bookkeeping, starve counter and next state.
  always_comb begin
    rf_we_next   = 1'b0;
    rf_addr_next = rf_addr_reg;
    rf_data_next = rf_data_reg;

    if (pipe_grant) begin
      rf_we_next   = 1'b1;
      rf_addr_next = i_pipe_addr;
      rf_data_next = i_pipe_data;
    end else if (pop) begin
      // An MDU result for r0 drains without writing.
      rf_we_next   = (mem_addr[rd_ptr_reg] != '0);
      rf_addr_next = mem_addr[rd_ptr_reg];
      rf_data_next = mem_data[rd_ptr_reg];
    end

    // Survivors after pop/squash stay contiguous starting at rd_after.
    keep_head   = head_valid && !pop && !squash[rd_ptr_reg];
    keep_second = second_valid && !squash[~rd_ptr_reg];
    count_after = {1'b0, keep_head} + {1'b0, keep_second};
    rd_after    = keep_head ? rd_ptr_reg : ~rd_ptr_reg;
    wr_after    = rd_after ^ count_after[0];

    count_next  = count_after + {1'b0, push};
    rd_ptr_next = rd_after;
    wr_ptr_next = wr_after ^ push;

    // Counts only while the same head stays in place without draining.
    starve_next = '0;
    if (keep_head) begin
      starve_next = (starve_reg == STARVE_MAX) ? starve_reg : starve_reg + 1'b1;
    end

    if ((state_reg != ST_FORCE) && keep_head && (starve_next == STARVE_MAX)) begin
      state_next = ST_FORCE;
    end else if (count_next != 2'd0) begin
      state_next = ST_PEND;
    end else begin
      state_next = ST_IDLE;
    end
  end

  // Control state, FIFO pointers and the registered write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      count_reg   <= 2'd0;
      rd_ptr_reg  <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      starve_reg  <= '0;
      rf_we_reg   <= 1'b0;
      rf_addr_reg <= '0;
      rf_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      starve_reg  <= starve_next;
      rf_we_reg   <= rf_we_next;
      rf_addr_reg <= rf_addr_next;
      rf_data_reg <= rf_data_next;
    end
  end

  // FIFO payload write; contents are only meaningful while counted valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wr_after] <= i_mdu_addr;
      mem_data[wr_after] <= i_mdu_data;
    end
  end

  assign o_mdu_ready  = (count_reg != 2'd2);
  assign o_stall_pipe = (state_reg == ST_FORCE);
  assign o_busy       = (count_reg != 2'd0);
  assign o_rf_we      = rf_we_reg;
  assign o_rf_addr    = rf_addr_reg;
  assign o_rf_data    = rf_data_reg;

  // wr_ptr_reg mirrors rd_ptr + count and is kept for observability of the
  // FIFO pointer pair.
  logic unused_ptr;
  assign unused_ptr = wr_ptr_reg;

endmodule
